ascon_ti_perm_ctrl: RTL and testbench
=====================================

Name: ascon_ti_perm_ctrl

Overview:
- Sequences the 3-share threshold-implementation Ascon permutation p^r over the five 64-bit lanes x0..x4.
- Holds the 3x320-bit share registers and injects the round constant.
- Drives the three TI S-box share functions, with a register between S-box and linear layer for glitch isolation, then applies the per-share linear layer.
- Sits between the masked AEAD mode FSM and the TI substitution layer; the mode FSM requests r rounds through a valid/ready handshake.

Parameters:
- MAX_ROUNDS, 12, largest round count accepted; also the base for round-constant indexing.
- RW, 4, width of the rounds request field.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  controller idle, request accepted this cycle if in_valid
- rounds_i  input  RW  rounds requested (0..MAX_ROUNDS)
- s0_i, s1_i, s2_i  input  320  input shares, lane x0 in [319:256] .. x4 in [63:0]
- rnd_i  input  640  fresh randomness (used only with REMASK_EN)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s0_o, s1_o, s2_o  output  320  output shares (direct from share registers)
- busy  output  1  high in SBOX or LIN
- round_o  output  RW  current round index, 0-based

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; busy=0; round_o=0; share registers=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch s0_i/s1_i/s2_i into the share registers and latch rounds_i. Clear the round counter. Go to SBOX if rounds_i!=0, else DONE.
  - SBOX, 1 cycle: compute the round constant, idx = MAX_ROUNDS - R + rcnt, where R is the latched round count and rcnt the round counter. rc = ((0xF-idx)<<4)|idx, zero-extended to 64 bits. XOR rc into share-0 x2 only. Feed all three shares to TI share functions 0/1/2; each function sees all shares and produces one output share. Register the outputs into the share registers. Go to LIN.
  - LIN, 1 cycle: apply the linear layer independently to each share (ror = rotate right):
    - x0 ^= ror(x0,19)^ror(x0,28)
    - x1 ^= ror(x1,61)^ror(x1,39)
    - x2 ^= ror(x2,1)^ror(x2,6)
    - x3 ^= ror(x3,10)^ror(x3,17)
    - x4 ^= ror(x4,7)^ror(x4,41)
    - Then increment rcnt. If the new rcnt==R go to DONE, else go to SBOX.
  - DONE: out_valid=1, shares stable. If out_ready, go to IDLE with out_valid=0 the next cycle. in_ready=0 while in DONE; no new request overlaps the held result.
- rounds_i > MAX_ROUNDS: saturate to MAX_ROUNDS at latch time.
- rounds_i == 0: pass-through; out_valid one cycle after acceptance with shares unchanged.
- Latency: acceptance edge to out_valid = 1 + 2R cycles (25 for R=12, 13 for R=6).
- Throughput: one permutation per 2R+2 cycles minimum (acceptance, 2R compute cycles, DONE, return to IDLE).
- Input stability:
  - in_valid ignored outside IDLE.
  - rounds_i and the shares are sampled only on the acceptance cycle.
  - out_ready ignored outside DONE.
- round_o equals rcnt; it holds at R in DONE.
- rst asserted mid-operation aborts the permutation: next cycle is IDLE with all outputs at reset values.
- The unmasked value s0^s1^s2 of the output must equal Ascon p^R of s0_i^s1_i^s2_i for any input sharing.
- The share registers are the only path between S-box and linear layer; no combinational path from S-box output to a module output.

Optional Feature:
- Macro: ASCON_TI_REMASK_EN.
- Defined: in each LIN cycle, after the linear layer, split rnd_i into r0=rnd_i[639:320] and r1=rnd_i[319:0]. Update s0^=r0, s1^=r1, s2^=r0^r1. The unmasked value is unchanged and the sharing is refreshed; the source must provide fresh rnd_i every LIN cycle.
- Not defined: rnd_i unused (lint waiver), no remask logic synthesised, and the output sharing is deterministic given the inputs.

Test Plan:
- Reset, then issue R=12 with s0_i=0, s1_i=0, s2_i=0. Required: out_valid exactly 25 cycles after acceptance; s0_o^s1_o^s2_o matches the software p12(0^320) model.
- Issue R=6 on a random state x split into random shares s0, s1 and s2=x^s0^s1. Required: out_valid after 13 cycles; XOR of the output shares equals p6(x). Repeat 1000 times, including with ASCON_TI_REMASK_EN and random rnd_i each cycle.
- rounds_i=0: out_valid 1 cycle after acceptance, outputs bit-identical to inputs. rounds_i=15: behaves as R=12 (25-cycle latency, round_o ends at 12).
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 pulsed meanwhile. Required: out_valid held, shares stable, in_ready=0, no request accepted. Release out_ready: IDLE next cycle, then the pulsed request is accepted.
- Assert rst for 1 cycle at round 5 of R=12. Required: next cycle out_valid=0, busy=0, in_ready=1, round_o=0, shares 0. A following R=12 request produces the correct result.
- Check round constants by probing share-0 x2 XOR input in SBOX cycles for R=12. Required sequence: 0xF0, 0xE1, 0xD2, ... 0x4B. For R=6 the sequence starts at 0x96.

Source files
------------

// File: rtl/ascon_ti_perm_ctrl.sv
// ascon_ti_perm_ctrl
// Round controller for the 3-share threshold-implementation Ascon
// permutation p^R. It holds three 320-bit share registers, injects the
// round constant into share 0, and evaluates three TI S-box share
// functions. Each function produces one output share from the other two
// input shares. The S-box result is registered before the per-share
// linear layer is applied in the following cycle.
// Optional feature: define ASCON_TI_REMASK_EN to refresh the sharing with
// rnd_i after every linear layer.
module ascon_ti_perm_ctrl #(
   parameter int MAX_ROUNDS = 12,
   parameter int RW         = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [RW-1:0] rounds_i,
   input  logic [319:0]  s0_i,
   input  logic [319:0]  s1_i,
   input  logic [319:0]  s2_i,
   input  logic [639:0]  rnd_i,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [319:0]  s0_o,
   output logic [319:0]  s1_o,
   output logic [319:0]  s2_o,
   output logic          busy,
   output logic [RW-1:0] round_o
);

   // Lane 0 (x0) maps onto bits [319:256], so index 0 is the MSB lane.
   typedef logic [0:4][63:0] lanes_t;

   typedef enum logic [1:0] {IDLE, SBOX, LIN, DONE} state_t;

   localparam logic [RW-1:0] MAX_R = RW'(MAX_ROUNDS);

   state_t        state;
   state_t        state_nxt;
   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_inc;
   logic [RW-1:0] rounds_q;
   logic [RW-1:0] rounds_sat;
   logic [RW-1:0] idx;
   logic [3:0]    idx4;
   logic [63:0]   rc;
   lanes_t        sh_q [3];
   lanes_t        sh_rc;
   lanes_t        sbox_out [3];
   lanes_t        lin_out [3];

   function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Affine input layer of the Ascon S-box, linear so it applies per share.
   function automatic lanes_t sbox_pre(input lanes_t x);
      lanes_t a;
      a    = x;
      a[0] = a[0] ^ a[4];
      a[4] = a[4] ^ a[3];
      a[2] = a[2] ^ a[1];
      return a;
   endfunction

   // One TI share function of the S-box. Output share j uses only input
   // shares other than j. The complement in chi is folded into share 0 and
   // the final NOT of x2 is also applied to share 0 only.
   function automatic lanes_t ti_sbox_share(input lanes_t x0, input lanes_t x1,
                                            input lanes_t x2, input int j);
      lanes_t a0, a1, a2, c;
      logic [63:0] na0, na1, na2, b0, b1, b2;
      int n, m;
      a0 = sbox_pre(x0);
      a1 = sbox_pre(x1);
      a2 = sbox_pre(x2);
      c  = '0;
      for (int i = 0; i < 5; i++) begin
         n   = (i + 1) % 5;
         m   = (i + 2) % 5;
         na0 = ~a0[n];
         na1 = a1[n];
         na2 = a2[n];
         b0  = a0[m];
         b1  = a1[m];
         b2  = a2[m];
         case (j)
            0:       c[i] = a1[i] ^ (na1 & b1) ^ (na1 & b2) ^ (na2 & b1);
            1:       c[i] = a2[i] ^ (na2 & b2) ^ (na2 & b0) ^ (na0 & b2);
            default: c[i] = a0[i] ^ (na0 & b0) ^ (na0 & b1) ^ (na1 & b0);
         endcase
      end
      c[1] = c[1] ^ c[0];
      c[0] = c[0] ^ c[4];
      c[3] = c[3] ^ c[2];
      if (j == 0) c[2] = ~c[2];
      return c;
   endfunction

   // Ascon linear diffusion layer for a single share.
   function automatic lanes_t lin_layer(input lanes_t x);
      lanes_t y;
      y[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
      y[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
      y[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
      y[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
      y[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
      return y;
   endfunction

   assign rounds_sat = (rounds_i > MAX_R) ? MAX_R : rounds_i;
   assign rcnt_inc   = rcnt + RW'(1);
   assign idx        = MAX_R - rounds_q + rcnt;
   assign idx4       = 4'(idx);
   assign rc         = {56'h0, 4'hF - idx4, idx4};

   // Round constant goes into lane x2 of share 0 only.
   always_comb begin
      sh_rc    = sh_q[0];
      sh_rc[2] = sh_q[0][2] ^ rc;
   end

   assign sbox_out[0] = ti_sbox_share(sh_rc, sh_q[1], sh_q[2], 0);
   assign sbox_out[1] = ti_sbox_share(sh_rc, sh_q[1], sh_q[2], 1);
   assign sbox_out[2] = ti_sbox_share(sh_rc, sh_q[1], sh_q[2], 2);

`ifdef ASCON_TI_REMASK_EN
   // Linear layer per share, then refresh the sharing with two fresh masks.
   always_comb begin
      lin_out[0] = lin_layer(sh_q[0]) ^ rnd_i[639:320];
      lin_out[1] = lin_layer(sh_q[1]) ^ rnd_i[319:0];
      lin_out[2] = lin_layer(sh_q[2]) ^ rnd_i[639:320] ^ rnd_i[319:0];
   end
`else
   // Linear layer per share; the sharing stays deterministic.
   always_comb begin
      lin_out[0] = lin_layer(sh_q[0]);
      lin_out[1] = lin_layer(sh_q[1]);
      lin_out[2] = lin_layer(sh_q[2]);
   end

   logic unused_rnd;
   assign unused_rnd = ^rnd_i;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (rounds_sat != '0) ? SBOX : DONE;
         end
         SBOX: begin
            busy      = 1'b1;
            state_nxt = LIN;
         end
         LIN: begin
            busy      = 1'b1;
            state_nxt = (rcnt_inc == rounds_q) ? DONE : SBOX;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Share registers, latched round count and round counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt     <= '0;
         rounds_q <= '0;
         for (int j = 0; j < 3; j++) sh_q[j] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh_q[0]  <= s0_i;
                  sh_q[1]  <= s1_i;
                  sh_q[2]  <= s2_i;
                  rounds_q <= rounds_sat;
                  rcnt     <= '0;
               end
            end
            SBOX: begin
               for (int j = 0; j < 3; j++) sh_q[j] <= sbox_out[j];
            end
            LIN: begin
               for (int j = 0; j < 3; j++) sh_q[j] <= lin_out[j];
               rcnt <= rcnt_inc;
            end
            default: ;
         endcase
      end
   end

   assign s0_o    = sh_q[0];
   assign s1_o    = sh_q[1];
   assign s2_o    = sh_q[2];
   assign round_o = rcnt;

endmodule

// File: tb/tb_ascon_ti_perm_ctrl.sv
// tb_ascon_ti_perm_ctrl
// Randomized bench for ascon_ti_perm_ctrl, checked against a table-driven
// software model of the Ascon permutation.
module tb_ascon_ti_perm_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   rounds_i = '0;
   logic [319:0] s0_i = '0;
   logic [319:0] s1_i = '0;
   logic [319:0] s2_i = '0;
   logic [639:0] rnd_i = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [319:0] s0_o;
   logic [319:0] s1_o;
   logic [319:0] s2_o;
   logic         busy;
   logic [3:0]   round_o;

   int errors = 0;
   int checks = 0;

   localparam logic [7:0] RC_TAB [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                          8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
   localparam logic [4:0] SBOX_TAB [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   ascon_ti_perm_ctrl #(.MAX_ROUNDS(12), .RW(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rounds_i(rounds_i), .s0_i(s0_i), .s1_i(s1_i), .s2_i(s2_i),
      .rnd_i(rnd_i), .out_valid(out_valid), .out_ready(out_ready),
      .s0_o(s0_o), .s1_o(s1_o), .s2_o(s2_o), .busy(busy), .round_o(round_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Reference Ascon p^r: constant addition, table S-box per bit column,
   // then the linear layer, using the last r of the twelve constants.
   function automatic logic [319:0] ascon_p(input logic [319:0] s, input int r);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  v, o;
      for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
      for (int rd = 12 - r; rd < 12; rd++) begin
         x[2] = x[2] ^ {56'h0, RC_TAB[rd]};
         for (int b = 0; b < 64; b++) begin
            v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX_TAB[v];
            y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2];
            y[3][b] = o[1]; y[4][b] = o[0];
         end
         x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
         x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
         x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
         x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
         x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Fresh masking randomness every cycle.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 20; i++) rnd_i[32*i +: 32] = $urandom;
      end
   end

   // Issue one request from IDLE, wait for out_valid, capture, then release.
   // lat counts cycles from the acceptance cycle (acceptance cycle = 0).
   task automatic run_perm(input int r, input logic [319:0] a, input logic [319:0] b,
                           input logic [319:0] c, output logic [319:0] o0,
                           output logic [319:0] o1, output logic [319:0] o2,
                           output int lat, output logic [3:0] rnd_end);
      @(negedge clk);
      in_valid = 1'b1;
      rounds_i = 4'(r);
      s0_i = a; s1_i = b; s2_i = c;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      o0 = s0_o; o1 = s1_o; o2 = s2_o;
      rnd_end = round_o;
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (round_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_round: got %0d expected 0", round_o); end
      checks++;
      if ((s0_o | s1_o | s2_o) !== 320'h0) begin errors++; $display("[TB] FAIL reset_shares: got %h expected 0", s0_o | s1_o | s2_o); end
      rst = 1'b0;
   endtask

   task automatic test_zero_p12();
      logic [319:0] o0, o1, o2, exp;
      int lat;
      logic [3:0] re;
      exp = ascon_p(320'h0, 12);
      run_perm(12, 320'h0, 320'h0, 320'h0, o0, o1, o2, lat, re);
      checks++;
      if (lat != 25) begin errors++; $display("[TB] FAIL p12_zero_latency: got %0d expected 25", lat); end
      checks++;
      if ((o0 ^ o1 ^ o2) !== exp) begin errors++; $display("[TB] FAIL p12_zero_value: got %h expected %h", o0 ^ o1 ^ o2, exp); end
      checks++;
      if (re !== 4'd12) begin errors++; $display("[TB] FAIL p12_zero_round: got %0d expected 12", re); end
   endtask

   task automatic test_random_r6();
      logic [319:0] x, a, b, o0, o1, o2, exp;
      int lat;
      logic [3:0] re;
      for (int n = 0; n < 1000; n++) begin
         x = rand320(); a = rand320(); b = rand320();
         exp = ascon_p(x, 6);
         run_perm(6, a, b, x ^ a ^ b, o0, o1, o2, lat, re);
         checks++;
         if (lat != 13) begin errors++; $display("[TB] FAIL r6_latency[%0d]: got %0d expected 13", n, lat); end
         checks++;
         if ((o0 ^ o1 ^ o2) !== exp) begin errors++; $display("[TB] FAIL r6_value[%0d]: got %h expected %h", n, o0 ^ o1 ^ o2, exp); end
      end
   endtask

   task automatic test_passthrough();
      logic [319:0] a, b, c, o0, o1, o2;
      int lat;
      logic [3:0] re;
      a = rand320(); b = rand320(); c = rand320();
      run_perm(0, a, b, c, o0, o1, o2, lat, re);
      checks++;
      if (lat != 1) begin errors++; $display("[TB] FAIL r0_latency: got %0d expected 1", lat); end
      checks++;
      if (o0 !== a) begin errors++; $display("[TB] FAIL r0_share0: got %h expected %h", o0, a); end
      checks++;
      if (o1 !== b) begin errors++; $display("[TB] FAIL r0_share1: got %h expected %h", o1, b); end
      checks++;
      if (o2 !== c) begin errors++; $display("[TB] FAIL r0_share2: got %h expected %h", o2, c); end
      checks++;
      if (re !== 4'd0) begin errors++; $display("[TB] FAIL r0_round: got %0d expected 0", re); end
   endtask

   task automatic test_saturate();
      logic [319:0] x, a, b, o0, o1, o2, exp;
      int lat;
      logic [3:0] re;
      x = rand320(); a = rand320(); b = rand320();
      exp = ascon_p(x, 12);
      run_perm(15, a, b, x ^ a ^ b, o0, o1, o2, lat, re);
      checks++;
      if (lat != 25) begin errors++; $display("[TB] FAIL sat_latency: got %0d expected 25", lat); end
      checks++;
      if (re !== 4'd12) begin errors++; $display("[TB] FAIL sat_round: got %0d expected 12", re); end
      checks++;
      if ((o0 ^ o1 ^ o2) !== exp) begin errors++; $display("[TB] FAIL sat_value: got %h expected %h", o0 ^ o1 ^ o2, exp); end
   endtask

   task automatic test_backpressure();
      logic [319:0] a0, a1, a2, xb, b0, b1, exp;
      int lat;
      a0 = rand320(); a1 = rand320(); a2 = rand320();
      xb = rand320(); b0 = rand320(); b1 = rand320();
      exp = ascon_p(xb, 3);
      @(negedge clk);
      in_valid = 1'b1; rounds_i = 4'd0; s0_i = a0; s1_i = a1; s2_i = a2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rounds_i = 4'd3; s0_i = b0; s1_i = b1; s2_i = xb ^ b0 ^ b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_handshake[%0d]: got valid=%b ready=%b expected valid=1 ready=0", k, out_valid, in_ready);
         end
         checks++;
         if (s0_o !== a0 || s1_o !== a1 || s2_o !== a2) begin
            errors++; $display("[TB] FAIL hold_shares[%0d]: got %h expected %h", k, s0_o, a0);
         end
         in_valid = (k % 2 == 0);
      end
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL release_idle: got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || round_o !== 4'd0) begin
         errors++; $display("[TB] FAIL pending_accept: got busy=%b round=%0d expected busy=1 round=0", busy, round_o);
      end
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 7) begin errors++; $display("[TB] FAIL pending_latency: got %0d expected 7", lat); end
      checks++;
      if ((s0_o ^ s1_o ^ s2_o) !== exp) begin errors++; $display("[TB] FAIL pending_value: got %h expected %h", s0_o ^ s1_o ^ s2_o, exp); end
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
   endtask

   task automatic test_abort();
      logic [319:0] x, a, b, o0, o1, o2, exp;
      int cyc, lat;
      logic [3:0] re;
      x = rand320(); a = rand320(); b = rand320();
      @(negedge clk);
      in_valid = 1'b1; rounds_i = 4'd12; s0_i = a; s1_i = b; s2_i = x ^ a ^ b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!(busy === 1'b1 && round_o === 4'd5) && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc >= 60) begin errors++; $display("[TB] FAIL abort_reach_round5: got timeout expected round 5"); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || round_o !== 4'd0) begin
         errors++; $display("[TB] FAIL abort_outputs: got valid=%b busy=%b ready=%b round=%0d expected 0 0 1 0", out_valid, busy, in_ready, round_o);
      end
      checks++;
      if ((s0_o | s1_o | s2_o) !== 320'h0) begin errors++; $display("[TB] FAIL abort_shares: got %h expected 0", s0_o | s1_o | s2_o); end
      @(negedge clk); rst = 1'b0;
      x = rand320(); a = rand320(); b = rand320();
      exp = ascon_p(x, 12);
      run_perm(12, a, b, x ^ a ^ b, o0, o1, o2, lat, re);
      checks++;
      if (lat != 25) begin errors++; $display("[TB] FAIL post_abort_latency: got %0d expected 25", lat); end
      checks++;
      if ((o0 ^ o1 ^ o2) !== exp) begin errors++; $display("[TB] FAIL post_abort_value: got %h expected %h", o0 ^ o1 ^ o2, exp); end
   endtask

   task automatic test_round_constants(input int r);
      int nbusy, cyc;
      logic [7:0] exp;
      @(negedge clk);
      in_valid = 1'b1; rounds_i = 4'(r);
      s0_i = rand320(); s1_i = rand320(); s2_i = rand320();
      @(posedge clk); #1;
      in_valid = 1'b0;
      nbusy = 0; cyc = 0;
      while (out_valid !== 1'b1 && cyc < 60) begin
         if (busy === 1'b1) begin
            nbusy++;
            exp = RC_TAB[12 - r + int'(round_o)];
            checks++;
            if (dut.rc !== {56'h0, exp}) begin
               errors++; $display("[TB] FAIL rc_r%0d_round%0d: got %h expected %h", r, round_o, dut.rc, exp);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (nbusy != 2 * r) begin errors++; $display("[TB] FAIL rc_r%0d_busy_cycles: got %0d expected %0d", r, nbusy, 2 * r); end
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_p12();
      test_passthrough();
      test_saturate();
      test_round_constants(12);
      test_round_constants(6);
      test_backpressure();
      test_abort();
      test_random_r6();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
